// File: rtl/shift_rotate_seq.sv
// Sequential shift/rotate unit: SRL/SLL take one pass through a shared 32-bit shifter,
// and ROR/ROL take two passes whose results are OR-combined.

module shift32 (
  input  logic [31:0] D,
  input  logic [31:0] S,
  input  logic        LnR,
  output logic [31:0] Y
);
  // Any amount of 32 or more shifts every bit out.
  always_comb begin
    Y = '0;
    if (S[31:5] == '0) begin
      Y = LnR ? (D << S[4:0]) : (D >> S[4:0]);
    end
  end
endmodule

module shift_rotate_seq #(
  parameter bit ROT_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  op,
  input  logic [31:0] D,
  input  logic [31:0] S,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Y,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] d_q, d_d;
  logic [31:0] s_q, s_d;
  logic [31:0] part_q, part_d;
  logic [31:0] y_q, y_d;

  logic        is_rot;
  logic        sh_lnr;
  logic [31:0] sh_amt;
  logic [31:0] sh_out;
  logic [5:0]  amt2;

  assign is_rot = ROT_EN && op_q[1];
  assign amt2   = 6'd32 - {1'b0, s_q[4:0]};

  // Shifter controls are kept apart from next-state logic so the shifter
  // output never feeds back into its own inputs within one block.
  always_comb begin
    sh_lnr = op_q[0];
    sh_amt = is_rot ? {27'b0, s_q[4:0]} : s_q;
    if (state_q == PASS2) begin
      sh_lnr = ~op_q[0];
      sh_amt = {26'b0, amt2};
    end
  end

  shift32 u_shift32 (
    .D   (d_q),
    .S   (sh_amt),
    .LnR (sh_lnr),
    .Y   (sh_out)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    d_d     = d_q;
    s_d     = s_q;
    part_d  = part_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = op;
          d_d     = D;
          s_d     = S;
          state_d = PASS1;
        end
      end
      PASS1: begin
        part_d = sh_out;
        if (!is_rot || (s_q[4:0] == 5'd0)) begin
          y_d     = sh_out;
          state_d = DONE;
        end else begin
          state_d = PASS2;
        end
      end
      PASS2: begin
        y_d     = part_q | sh_out;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      op_q    <= '0;
      d_q     <= '0;
      s_q     <= '0;
      part_q  <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      d_q     <= d_d;
      s_q     <= s_d;
      part_q  <= part_d;
      y_q     <= y_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Y         = y_q;
endmodule

// File: tb/tb_shift_rotate_seq.sv
// Scoreboard bench for shift_rotate_seq: one rotate-enabled and one rotate-disabled instance,
// directed vectors with hand-computed results and latencies.

module tb_shift_rotate_seq;
  localparam logic [1:0] SRL = 2'b00, SLL = 2'b01, ROR = 2'b10, ROL = 2'b11;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  op;
  logic [31:0] D, S;
  logic        out_ready;
  logic        rv0, rr0, ov0, bz0;
  logic        rv1, rr1, ov1, bz1;
  logic [31:0] y0, y1;

  typedef struct {
    logic [31:0] y;
    int          lat;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0, acc0 = 0, acc1 = 0;
  logic ovp0 = 1'b0, ovp1 = 1'b0;

  always #5 CLK = ~CLK;

  shift_rotate_seq #(.ROT_EN(1'b1)) dut0 (
    .CLK(CLK), .RST(RST), .req_valid(rv0), .req_ready(rr0), .op(op), .D(D), .S(S),
    .out_valid(ov0), .out_ready(out_ready), .Y(y0), .busy(bz0)
  );

  shift_rotate_seq #(.ROT_EN(1'b0)) dut1 (
    .CLK(CLK), .RST(RST), .req_valid(rv1), .req_ready(rr1), .op(op), .D(D), .S(S),
    .out_valid(ov1), .out_ready(out_ready), .Y(y1), .busy(bz1)
  );

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm, input int n);
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles", nm, n);
  endtask

  // Edge counter; latency = edges from the accept edge (inclusive) to out_valid.
  always @(posedge CLK) begin
    if (!RST && rv0 && rr0) acc0 <= cyc;
    if (!RST && rv1 && rr1) acc1 <= cyc;
    cyc <= cyc + 1;
  end

  always @(negedge CLK) begin
    if (ov0 && !ovp0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0 unexpected out_valid: Y=%h, no result expected", y0);
      end else begin
        e0 = q0.pop_front();
        check32({e0.name, " Y"}, y0, e0.y);
        check32({e0.name, " latency"}, 32'(cyc - acc0), 32'(e0.lat));
      end
    end
    ovp0 = ov0;
    if (ov1 && !ovp1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 unexpected out_valid: Y=%h, no result expected", y1);
      end else begin
        e1 = q1.pop_front();
        check32({e1.name, " Y"}, y1, e1.y);
        check32({e1.name, " latency"}, 32'(cyc - acc1), 32'(e1.lat));
      end
    end
    ovp1 = ov1;
  end

  task automatic issue(input int which, input logic [1:0] o, input logic [31:0] d,
                       input logic [31:0] s, input logic [31:0] ey, input int lat,
                       input string nm, input bit push);
    int n = 0;
    @(negedge CLK);
    op = o;
    D  = d;
    S  = s;
    if (which == 0) rv0 = 1'b1;
    else            rv1 = 1'b1;
    while (((which == 0) ? rr0 : rr1) !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 40) timeout({nm, " accept"}, n);
    else if (push) begin
      if (which == 0) q0.push_back('{ey, lat, nm});
      else            q1.push_back('{ey, lat, nm});
    end
    @(posedge CLK);
    #1;
    rv0 = 1'b0;
    rv1 = 1'b0;
    op  = ~o;
    D   = ~d;
    S   = s ^ 32'h0000_0013;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || rr0 !== 1'b1 || rr1 !== 1'b1) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) timeout({nm, " drain"}, n);
  endtask

  initial begin
    int n;
    RST = 1'b1; rv0 = 1'b0; rv1 = 1'b0; op = '0; D = '0; S = '0; out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    check32("reset Y", y0, 32'h0);
    check1("reset out_valid", ov0, 1'b0);
    check1("reset busy", bz0, 1'b0);
    check1("reset req_ready", rr0, 1'b1);
    RST = 1'b0;

    issue(0, SRL, 32'h8000_0001, 32'd4,          32'h0800_0000, 2, "srl4",      1);
    issue(0, SLL, 32'h0000_00FF, 32'd28,         32'hF000_0000, 2, "sll28",     1);
    issue(0, SLL, 32'hFFFF_FFFF, 32'd32,         32'h0000_0000, 2, "sll32",     1);
    issue(0, SRL, 32'hFFFF_FFFF, 32'h8000_0001,  32'h0000_0000, 2, "srl_big",   1);
    issue(0, SRL, 32'h8000_0000, 32'd31,         32'h0000_0001, 2, "srl31",     1);
    issue(0, ROR, 32'h0000_0001, 32'd1,          32'h8000_0000, 3, "ror1",      1);
    issue(0, ROL, 32'h8000_000F, 32'd4,          32'h0000_00F8, 3, "rol4",      1);
    issue(0, ROR, 32'h1234_5678, 32'd32,         32'h1234_5678, 2, "ror32",     1);
    issue(0, ROR, 32'h0000_0003, 32'd33,         32'h8000_0001, 3, "ror33",     1);
    issue(0, ROL, 32'h1234_5678, 32'd8,          32'h3456_7812, 3, "rol8",      1);
    drain("main");

    issue(0, SRL, 32'h0000_F000, 32'd4,          32'h0000_0F00, 2, "pre_rst",   1);
    drain("pre_rst");
    check32("Y held in idle", y0, 32'h0000_0F00);
    issue(0, ROR, 32'h0000_000F, 32'd4,          32'h0,         3, "aborted",   0);
    @(posedge CLK);
    #1;
    check1("busy in pass2", bz0, 1'b1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check1("mid-op reset out_valid", ov0, 1'b0);
    check32("mid-op reset Y", y0, 32'h0);
    check1("mid-op reset req_ready", rr0, 1'b1);
    check1("mid-op reset busy", bz0, 1'b0);
    repeat (6) @(negedge CLK);
    check1("no pulse after reset", ov0, 1'b0);

    out_ready = 1'b0;
    issue(0, SLL, 32'h0000_0001, 32'd5,          32'h0000_0020, 2, "bp_first",  1);
    n = 0;
    while (ov0 !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) timeout("bp out_valid", n);
    op = SRL; D = 32'h8000_0000; S = 32'd1; rv0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check1("bp out_valid held", ov0, 1'b1);
      check32("bp Y held", y0, 32'h0000_0020);
      check1("bp req_ready low", rr0, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge CLK);
    check1("bp release out_valid", ov0, 1'b0);
    check1("bp release req_ready", rr0, 1'b1);
    q0.push_back('{32'h4000_0000, 2, "bp_second"});
    @(posedge CLK);
    #1;
    rv0 = 1'b0;
    drain("backpressure");

    issue(1, ROR, 32'h0000_0001, 32'd1,          32'h0000_0000, 2, "norot_ror1",  1);
    issue(1, ROL, 32'h0000_0001, 32'd4,          32'h0000_0010, 2, "norot_rol4",  1);
    issue(1, ROR, 32'h8000_0000, 32'd33,         32'h0000_0000, 2, "norot_ror33", 1);
    drain("norot");

    check32("scoreboard empty", 32'(q0.size() + q1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
